sr_cmd_sequencer: RTL and testbench

SR_CMD_SEQUENCER -- requirements
Module: sr_cmd_sequencer

---
 rtl/sr_pkg.sv | 21 ++
 rtl/sr_debounce.sv | 60 ++++++
 rtl/sr_cmd_sequencer.sv | 134 +++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types for the SR latch command sequencer.
// Optional input debounce is enabled with SR_DEBOUNCE_EN.
package sr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ENABLE,
      ST_RELEASE
   } state_e;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_SET,
      CMD_RESET
   } cmd_e;

   localparam int EN_CNT_W = 4;
   localparam int DB_CNT_W = 8;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer plus optional stability filter for one request input.
// With SR_DEBOUNCE_EN undefined the synchronizer output is the level directly.
module sr_debounce
   import sr_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic din_i,
   output logic level_o
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
      $error("DEBOUNCE_CYCLES out of range");
   end

   logic [1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], din_i};
      end
   end

`ifdef SR_DEBOUNCE_EN
   logic [DB_CNT_W-1:0] cnt_q, cnt_d;
   logic                level_q, level_d;

   // Counter only runs while the synced input disagrees with the level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_q[1] != level_q) begin
         if (cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + DB_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;
`else
   assign level_o = sync_q[1];
`endif

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Sequences set/reset commands into setup/enable/release drive of an SR latch.
// Input debounce counters are present only with SR_DEBOUNCE_EN defined.
module sr_cmd_sequencer
   import sr_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned EN_PULSE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic rst_req,
   output logic s_out,
   output logic r_out,
   output logic en_out,
   output logic busy,
   output logic conflict
);

   if (EN_PULSE_CYCLES < 1 || EN_PULSE_CYCLES > 15) begin : g_bad_en
      $error("EN_PULSE_CYCLES out of range");
   end

   logic set_lvl, rst_lvl;
   logic set_prev_q, rst_prev_q;
   logic set_rise, rst_rise;
   logic want_set, want_rst;
   logic conflict_q, conflict_d;

   state_e state_q, state_d;
   cmd_e   cmd_q, cmd_d;
   cmd_e   pend_q, pend_d;
   cmd_e   req;

   logic [EN_CNT_W-1:0] cnt_q, cnt_d;

   sr_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_set (
      .clk_i  (clk),
      .rst_i  (rst),
      .din_i  (set_req),
      .level_o(set_lvl)
   );

   sr_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_rst (
      .clk_i  (clk),
      .rst_i  (rst),
      .din_i  (rst_req),
      .level_o(rst_lvl)
   );

   assign set_rise = set_lvl & ~set_prev_q;
   assign rst_rise = rst_lvl & ~rst_prev_q;

   // Fresh edges and the pending slot are merged before arbitration.
   assign want_set = set_rise | (pend_q == CMD_SET);
   assign want_rst = rst_rise | (pend_q == CMD_RESET);

   always_comb begin
      req        = CMD_NONE;
      conflict_d = 1'b0;
      unique case (1'b1)
         want_set & want_rst:  conflict_d = 1'b1;
         want_set & ~want_rst: req = CMD_SET;
         want_rst & ~want_set: req = CMD_RESET;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      cnt_d   = cnt_q;
      pend_d  = req;
      unique case (state_q)
         ST_IDLE: begin
            if (req != CMD_NONE) begin
               state_d = ST_SETUP;
               cmd_d   = req;
               pend_d  = CMD_NONE;
            end
         end
         ST_SETUP: begin
            state_d = ST_ENABLE;
            cnt_d   = '0;
         end
         ST_ENABLE: begin
            if (cnt_q == EN_CNT_W'(EN_PULSE_CYCLES - 1)) begin
               state_d = ST_RELEASE;
            end else begin
               cnt_d = cnt_q + EN_CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
            cmd_d   = CMD_NONE;
         end
         default: begin
            state_d = ST_IDLE;
            cmd_d   = CMD_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cmd_q      <= CMD_NONE;
         pend_q     <= CMD_NONE;
         cnt_q      <= '0;
         conflict_q <= 1'b0;
         set_prev_q <= 1'b0;
         rst_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         conflict_q <= conflict_d;
         set_prev_q <= set_lvl;
         rst_prev_q <= rst_lvl;
      end
   end

   assign s_out    = (cmd_q == CMD_SET);
   assign r_out    = (cmd_q == CMD_RESET);
   assign en_out   = (state_q == ST_ENABLE);
   assign busy     = (state_q != ST_IDLE);
   assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Scoreboard bench for sr_cmd_sequencer; builds with or without SR_DEBOUNCE_EN.
module tb_sr_cmd_sequencer;

   localparam int DB = 4;
   localparam int EN = 2;
`ifdef SR_DEBOUNCE_EN
   localparam int LAT = 3 + DB;
`else
   localparam int LAT = 3;
`endif
   localparam int K_SET = 1;
   localparam int K_RST = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic set_req = 1'b0;
   logic rst_req = 1'b0;
   logic s_out, r_out, en_out, busy, conflict;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int kind;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   conf_q[$];

   sr_cmd_sequencer #(
      .DEBOUNCE_CYCLES(DB),
      .EN_PULSE_CYCLES(EN)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .set_req (set_req),
      .rst_req (rst_req),
      .s_out   (s_out),
      .r_out   (r_out),
      .en_out  (en_out),
      .busy    (busy),
      .conflict(conflict)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic push_cmd(input int kind, input int c);
      exp_t e;
      e.kind = kind;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   bit mon_act = 1'b0;
   int ph = 0;
   int cur = 0;

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst) begin
         mon_act = 1'b0;
         ph = 0;
      end else begin
         if (busy && !mon_act) begin
            mon_act = 1'b1;
            ph = 0;
            if (exp_q.size() == 0) begin
               check("unexp_cmd", cyc, -1);
               cur = 0;
            end else begin
               e = exp_q.pop_front();
               cur = e.kind;
               check("start_cyc", cyc, e.cyc);
            end
         end
         if (mon_act && busy) begin
            check("s_out", int'(s_out), int'(cur == K_SET));
            check("r_out", int'(r_out), int'(cur == K_RST));
            check("en_out", int'(en_out), int'(ph >= 1 && ph <= EN));
            ph++;
         end else if (mon_act) begin
            check("cmd_len", ph, EN + 2);
            mon_act = 1'b0;
         end
         if (!busy) begin
            check("idle_s", int'(s_out), 0);
            check("idle_r", int'(r_out), 0);
            check("idle_en", int'(en_out), 0);
         end
         check("sr_excl", int'(s_out & r_out), 0);
         if (conflict) begin
            if (conf_q.size() == 0) check("unexp_conflict", cyc, -1);
            else check("conflict_cyc", cyc, conf_q.pop_front());
         end
      end
   end

   initial begin
      int c0;
      repeat (3) @(negedge clk);
      check("rst_s", int'(s_out), 0);
      check("rst_r", int'(r_out), 0);
      check("rst_en", int'(en_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_conflict", int'(conflict), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // single set
      c0 = cyc;
      set_req = 1'b1;
      push_cmd(K_SET, c0 + LAT);
      repeat (LAT + EN + 6) @(negedge clk);
      set_req = 1'b0;
      repeat (LAT + 6) @(negedge clk);

      // short glitch
      c0 = cyc;
      set_req = 1'b1;
      repeat (3) @(negedge clk);
      set_req = 1'b0;
`ifndef SR_DEBOUNCE_EN
      push_cmd(K_SET, c0 + LAT);
`endif
      repeat (LAT + EN + 8) @(negedge clk);

      // single reset
      c0 = cyc;
      rst_req = 1'b1;
      push_cmd(K_RST, c0 + LAT);
      repeat (LAT + EN + 6) @(negedge clk);
      rst_req = 1'b0;
      repeat (LAT + 6) @(negedge clk);

      // simultaneous requests
      c0 = cyc;
      set_req = 1'b1;
      rst_req = 1'b1;
      conf_q.push_back(c0 + LAT);
      repeat (LAT + 6) @(negedge clk);
      set_req = 1'b0;
      rst_req = 1'b0;
      repeat (LAT + 6) @(negedge clk);

      // reset request queued behind a set in ENABLE
      c0 = cyc;
      set_req = 1'b1;
      push_cmd(K_SET, c0 + LAT);
      repeat (2) @(negedge clk);
      rst_req = 1'b1;
      push_cmd(K_RST, c0 + LAT + EN + 3);
      repeat (LAT + 2 * EN + 10) @(negedge clk);
      set_req = 1'b0;
      rst_req = 1'b0;
      repeat (LAT + 6) @(negedge clk);

      // reset in the middle of ENABLE
      c0 = cyc;
      set_req = 1'b1;
      push_cmd(K_SET, c0 + LAT);
      repeat (LAT + 1) @(negedge clk);
      check("pre_rst_en", int'(en_out), 1);
      set_req = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_s", int'(s_out), 0);
      check("mid_rst_r", int'(r_out), 0);
      check("mid_rst_en", int'(en_out), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_conflict", int'(conflict), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (LAT + 12) @(negedge clk);

      check("exp_q_left", exp_q.size(), 0);
      check("conf_q_left", conf_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
